debounce_bank: RTL and testbench
================================

// Module: debounce_bank
// PURPOSE
//  Multi-channel debouncer for push-buttons/switches with edge and long-press/auto-repeat events.
//  Each channel: 2-flop synchroniser, consecutive-mismatch counter, stable level, rise/fall pulses, hold FSM.
//  Sits between raw board inputs and control FSMs (menu/counter logic); replaces per-button single-channel debouncers.
// PARAMETERS
//  N_CH          4        number of independent channels (>=1)
//  TD_CYCLES     1000000  consecutive stable cycles required to accept a new level (>=1; 10 ms @100 MHz)
//  HOLD_CYCLES   50000000 cycles level must stay active after rise before long_press fires (>=1)
//  REPEAT_CYCLES 10000000 auto-repeat period after long_press; 0 = no repeat
//  ACTIVE_LOW    0        1: raw inputs inverted before sync (pressed = 0 on pin)
// PORTS
//  clk         in   1     system clock
//  rst_n       in   1     asynchronous active-low reset
//  x           in   N_CH  raw asynchronous inputs
//  y           out  N_CH  debounced level (1 = active, after polarity fix)
//  rise        out  N_CH  1-cycle pulse: y went 0->1
//  fall        out  N_CH  1-cycle pulse: y went 1->0
//  long_press  out  N_CH  1-cycle pulse: y active for HOLD_CYCLES
//  repeat_p    out  N_CH  1-cycle pulse every REPEAT_CYCLES while held past long_press
// BEHAVIOUR
//  Reset (rst_n=0, async, any time incl. mid-count): sync flops, counters, y, all pulses -> 0; FSM -> IDLE.
//  Polarity: xi = ACTIVE_LOW ? ~x : x, applied before synchroniser.
//  Sync: s1<=xi; s2<=s1. Only s2 used downstream.
//  Debounce counter dcnt (per ch): s2==y -> dcnt<=0; else dcnt==TD_CYCLES-1 -> y<=s2, dcnt<=0; else dcnt++.
//  Latency: level sampled into s1 at edge k, held stable -> y changes at edge k+1+TD_CYCLES.
//  Glitch: any cycle with s2==y before terminal count clears dcnt; pulses shorter than TD_CYCLES never pass.
//  rise/fall registered: asserted in the same cycle y first shows its new value, cleared next edge.
//  Hold FSM per channel, hcnt counter:
//   IDLE    : y=0. On rise edge -> PRESSED, hcnt<=0.
//   PRESSED : hcnt++; hcnt==HOLD_CYCLES-1 -> long_press pulse, hcnt<=0, -> HELD.
//   HELD    : REPEAT_CYCLES==0: stay, hcnt frozen. Else hcnt++; hcnt==REPEAT_CYCLES-1 -> repeat_p, hcnt<=0.
//   Any state: fall (y 1->0) -> IDLE, hcnt<=0; no long_press/repeat_p that cycle.
//  Simultaneous: fall wins over long_press/repeat terminal count in same cycle.
//  long_press fires at edge r+HOLD_CYCLES (r = edge where y rose); first repeat_p at +REPEAT_CYCLES after.
//  At most one of rise/fall/long_press/repeat_p set per channel per cycle; channels fully independent.
//  Widths: DW=$clog2(TD_CYCLES+1), HW=$clog2(max(HOLD_CYCLES,REPEAT_CYCLES)+1); counters never wrap.
//  All outputs registered; no combinational path x->outputs.
// STRUCTURE
//  debounce_pkg: hold_state_t enum {IDLE,PRESSED,HELD}; function cnt_width(int) (clog2 helper).
//  Sub-module debounce_channel (one channel, same params minus N_CH); top = generate loop over N_CH.
// TESTING  (N_CH=4, TD_CYCLES=8, HOLD_CYCLES=20, REPEAT_CYCLES=5, ACTIVE_LOW=0 unless noted)
//  1 ch0 0->1 held: y[0]=1 and rise[0]=1 exactly 9 edges after sampling edge; fall on release 9 edges later.
//  2 ch1 bounce 1,0,1,0 (3-cycle widths) then stable 1: y[1] stays 0 until 8 stable sync cycles, single rise.
//  3 ch2 held 50 cycles: long_press at rise+20, repeat_p at +25,+30,...; release -> fall, no more pulses.
//  4 release landing on long_press terminal cycle: fall=1, long_press=0; FSM IDLE.
//  5 rst_n low mid-count/mid-hold on all channels: outputs 0 immediately (async); no pulse after release.
//  6 ACTIVE_LOW=1, REPEAT_CYCLES=0: pin idle 1 -> y=0; pin 0 held 40 -> one long_press, zero repeat_p.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared definitions for the debounce bank.
//   hold_state_t : per-channel press/hold state (IDLE, PRESSED, HELD)
//   cnt_width()  : bits needed to hold counts 0..v (minimum 1)
//   max_int()    : larger of two integers, for sizing the shared hold/repeat counter
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } hold_state_t;

  function automatic int cnt_width(input int v);
    if (v < 1) return 1;
    return $clog2(v + 1);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: polarity fix, 2-flop synchroniser, consecutive-mismatch
// counter producing a stable level, rise/fall pulses and a long-press /
// auto-repeat hold FSM.
// Ports:
//   clk        in  system clock
//   rst_n      in  asynchronous active-low reset
//   x          in  raw asynchronous input
//   y          out debounced level (1 = active)
//   rise       out 1-cycle pulse when y goes 0->1
//   fall       out 1-cycle pulse when y goes 1->0
//   long_press out 1-cycle pulse when y has been active HOLD_CYCLES
//   repeat_p   out 1-cycle pulse every REPEAT_CYCLES after long_press (0 = none)
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int TD_CYCLES     = 1000000,
  parameter int HOLD_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000,
  parameter bit ACTIVE_LOW    = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic x,
  output logic y,
  output logic rise,
  output logic fall,
  output logic long_press,
  output logic repeat_p
);

  localparam int DW = cnt_width(TD_CYCLES);
  localparam int HW = cnt_width(max_int(HOLD_CYCLES, REPEAT_CYCLES));
  localparam logic [DW-1:0] D_TERM = DW'(TD_CYCLES - 1);
  localparam logic [HW-1:0] H_TERM = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] R_TERM = HW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

  logic          xi;
  logic          s1_q, s2_q;
  logic          y_q, y_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          rise_ev, fall_ev;
  logic          rise_q, fall_q, lp_q, lp_d, rp_q, rp_d;
  hold_state_t   state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;

  assign xi = ACTIVE_LOW ? ~x : x;

  // Debounce: any sample agreeing with the current level restarts the count,
  // so only an unbroken run of TD_CYCLES disagreeing samples changes y.
  always_comb begin
    y_d    = y_q;
    dcnt_d = dcnt_q;
    if (s2_q == y_q) begin
      dcnt_d = '0;
    end else if (dcnt_q == D_TERM) begin
      y_d    = s2_q;
      dcnt_d = '0;
    end else begin
      dcnt_d = dcnt_q + 1'b1;
    end
  end

  assign rise_ev = y_d & ~y_q;
  assign fall_ev = ~y_d & y_q;

  // Hold FSM reacts to the level change in the same edge it is registered,
  // so long_press lands exactly HOLD_CYCLES edges after the rise edge.
  // A fall overrides any terminal count reached in the same cycle.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    lp_d    = 1'b0;
    rp_d    = 1'b0;
    if (fall_ev) begin
      state_d = IDLE;
      hcnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise_ev) begin
            state_d = PRESSED;
            hcnt_d  = '0;
          end
        end
        PRESSED: begin
          if (hcnt_q == H_TERM) begin
            lp_d    = 1'b1;
            hcnt_d  = '0;
            state_d = HELD;
          end else begin
            hcnt_d = hcnt_q + 1'b1;
          end
        end
        HELD: begin
          // With repeat disabled the counter simply stays frozen here.
          if (REPEAT_CYCLES != 0) begin
            if (hcnt_q == R_TERM) begin
              rp_d   = 1'b1;
              hcnt_d = '0;
            end else begin
              hcnt_d = hcnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          hcnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      y_q     <= 1'b0;
      dcnt_q  <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      lp_q    <= 1'b0;
      rp_q    <= 1'b0;
      state_q <= IDLE;
      hcnt_q  <= '0;
    end else begin
      s1_q    <= xi;
      s2_q    <= s1_q;
      y_q     <= y_d;
      dcnt_q  <= dcnt_d;
      rise_q  <= rise_ev;
      fall_q  <= fall_ev;
      lp_q    <= lp_d;
      rp_q    <= rp_d;
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
    end
  end

  assign y          = y_q;
  assign rise       = rise_q;
  assign fall       = fall_q;
  assign long_press = lp_q;
  assign repeat_p   = rp_q;

endmodule

// File: rtl/debounce_bank.sv
// Multi-channel debouncer: N_CH independent debounce_channel instances.
// Ports:
//   clk        in  system clock
//   rst_n      in  asynchronous active-low reset
//   x          in  [N_CH] raw asynchronous inputs
//   y          out [N_CH] debounced levels (1 = active)
//   rise       out [N_CH] 1-cycle pulse on y 0->1
//   fall       out [N_CH] 1-cycle pulse on y 1->0
//   long_press out [N_CH] 1-cycle pulse after y active HOLD_CYCLES
//   repeat_p   out [N_CH] auto-repeat pulse every REPEAT_CYCLES after long_press
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int TD_CYCLES     = 1000000,
  parameter int HOLD_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000,
  parameter bit ACTIVE_LOW    = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] x,
  output logic [N_CH-1:0] y,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] long_press,
  output logic [N_CH-1:0] repeat_p
);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_channel #(
      .TD_CYCLES    (TD_CYCLES),
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES),
      .ACTIVE_LOW   (ACTIVE_LOW)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .x         (x[g]),
      .y         (y[g]),
      .rise      (rise[g]),
      .fall      (fall[g]),
      .long_press(long_press[g]),
      .repeat_p  (repeat_p[g])
    );
  end

endmodule

// File: tb/tb_debounce_bank.sv
module tb_debounce_bank;

  localparam int NC   = 4;
  localparam int TD   = 8;
  localparam int HOLD = 20;
  localparam int REP  = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NC-1:0] x0 = '0;
  logic [NC-1:0] x1 = '1;
  logic [NC-1:0] y0, r0, f0, lp0, rp0;
  logic [NC-1:0] y1, r1, f1, lp1, rp1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  debounce_bank #(.N_CH(NC), .TD_CYCLES(TD), .HOLD_CYCLES(HOLD),
                  .REPEAT_CYCLES(REP), .ACTIVE_LOW(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .x(x0), .y(y0), .rise(r0), .fall(f0),
    .long_press(lp0), .repeat_p(rp0));

  debounce_bank #(.N_CH(NC), .TD_CYCLES(TD), .HOLD_CYCLES(HOLD),
                  .REPEAT_CYCLES(0), .ACTIVE_LOW(1'b1)) u_al (
    .clk(clk), .rst_n(rst_n), .x(x1), .y(y1), .rise(r1), .fall(f1),
    .long_press(lp1), .repeat_p(rp1));

  // Reference model: "run" = length of the current streak of synchronised
  // samples that disagree with the accepted level; "age" = edges since y rose.
  typedef struct packed {
    bit s1, s2, y, rise, fall, lp, rp;
    int run;
    int age;
  } ch_t;

  ch_t m0 [NC];
  ch_t m1 [NC];

  function automatic ch_t step(input ch_t c, input bit xi, input int rep);
    ch_t n;
    n = c;
    n.rise = 0; n.fall = 0; n.lp = 0; n.rp = 0;
    if (c.s2 == c.y) n.run = 0;
    else begin
      n.run = c.run + 1;
      if (n.run == TD) begin
        n.y = c.s2;
        n.run = 0;
        if (n.y) n.rise = 1; else n.fall = 1;
      end
    end
    if (n.fall || n.rise) n.age = 0;
    else if (c.y) begin
      n.age = c.age + 1;
      if (n.age == HOLD) n.lp = 1;
      else if (rep != 0 && n.age > HOLD && (n.age - HOLD) % rep == 0) n.rp = 1;
    end
    n.s2 = c.s1;
    n.s1 = xi;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NC; i++) begin m0[i] = '0; m1[i] = '0; end
    end else begin
      for (int i = 0; i < NC; i++) begin
        m0[i] = step(m0[i], x0[i], REP);
        m1[i] = step(m1[i], ~x1[i], 0);
      end
    end
  end

  function automatic logic [39:0] expv();
    logic [3:0] a, b, c, d, e, a1, b1, c1, d1, e1;
    for (int i = 0; i < NC; i++) begin
      a[i] = m0[i].y; b[i] = m0[i].rise; c[i] = m0[i].fall; d[i] = m0[i].lp; e[i] = m0[i].rp;
      a1[i] = m1[i].y; b1[i] = m1[i].rise; c1[i] = m1[i].fall; d1[i] = m1[i].lp; e1[i] = m1[i].rp;
    end
    return {a, b, c, d, e, a1, b1, c1, d1, e1};
  endfunction

  function automatic logic [39:0] obsv();
    return {y0, r0, f0, lp0, rp0, y1, r1, f1, lp1, rp1};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    x0 = '0; x1 = '1;
    repeat (3) tick();
    n_vec++;
    if (obsv() !== 40'h0) begin
      n_err++; $display("FAIL reset_state got=%h exp=%h", obsv(), 40'h0);
    end
    rst_n = 1'b1;
    for (int e = 0; e < 12; e++) begin
      tick();
      n_vec++;
      if (obsv() !== expv()) begin
        n_err++; $display("FAIL idle_cycle e=%0d got=%h exp=%h", e, obsv(), expv());
      end
    end
  endtask

  task automatic test_edge_latency();
    x0[0] = 1'b1;
    for (int e = 0; e < 22; e++) begin
      tick();
      n_vec++;
      if (obsv() !== expv()) begin
        n_err++; $display("FAIL edge_model e=%0d got=%h exp=%h", e, obsv(), expv());
      end
      if (e == 8) begin
        n_vec++;
        if (y0[0] !== 1'b0) begin n_err++; $display("FAIL rise_early y=%b exp=0", y0[0]); end
      end
      if (e == 9) begin
        n_vec++;
        if ({y0[0], r0[0]} !== 2'b11) begin
          n_err++; $display("FAIL rise_latency y_rise=%b exp=11", {y0[0], r0[0]});
        end
        x0[0] = 1'b0;
      end
      if (e == 10) begin
        n_vec++;
        if ({y0[0], r0[0]} !== 2'b10) begin
          n_err++; $display("FAIL rise_width y_rise=%b exp=10", {y0[0], r0[0]});
        end
      end
      if (e == 19) begin
        n_vec++;
        if ({y0[0], f0[0]} !== 2'b01) begin
          n_err++; $display("FAIL fall_latency y_fall=%b exp=01", {y0[0], f0[0]});
        end
      end
    end
  endtask

  task automatic test_bounce();
    bit pat [12] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0};
    int n_rise = 0;
    int rise_at = -1;
    for (int e = 0; e < 50; e++) begin
      x0[1] = (e < 12) ? pat[e] : (e < 36);
      tick();
      n_vec++;
      if (obsv() !== expv()) begin
        n_err++; $display("FAIL bounce_model e=%0d got=%h exp=%h", e, obsv(), expv());
      end
      if (r0[1]) begin n_rise++; rise_at = e; end
    end
    n_vec++;
    if (n_rise !== 1 || rise_at !== 21) begin
      n_err++; $display("FAIL bounce_rise count=%0d at=%0d exp=1 at 21", n_rise, rise_at);
    end
  endtask

  task automatic test_hold_repeat();
    int r = -1, lp_e = -1, fall_e = -1, n_lp = 0, n_rp = 0, bad_rp = 0, late = 0;
    for (int e = 0; e < 90; e++) begin
      x0[2] = (e < 50);
      tick();
      n_vec++;
      if (obsv() !== expv()) begin
        n_err++; $display("FAIL hold_model e=%0d got=%h exp=%h", e, obsv(), expv());
      end
      if (r0[2]) r = e;
      if (f0[2]) fall_e = e;
      if (lp0[2]) begin n_lp++; lp_e = e; end
      if (rp0[2]) begin
        n_rp++;
        if (r < 0 || (e - r) <= HOLD || ((e - r - HOLD) % REP) != 0) bad_rp++;
      end
      if (fall_e >= 0 && e > fall_e && (lp0[2] || rp0[2])) late++;
    end
    n_vec++;
    if (r !== 9 || lp_e - r !== HOLD || n_lp !== 1) begin
      n_err++; $display("FAIL long_press r=%0d lp=%0d n=%0d exp r=9 lp=29 n=1", r, lp_e, n_lp);
    end
    n_vec++;
    if (n_rp !== 5 || bad_rp !== 0) begin
      n_err++; $display("FAIL repeat_count n=%0d bad=%0d exp n=5 bad=0", n_rp, bad_rp);
    end
    n_vec++;
    if (fall_e - r !== 50 || late !== 0) begin
      n_err++; $display("FAIL release_after_hold fall=%0d late=%0d exp fall=r+50 late=0", fall_e, late);
    end
  endtask

  task automatic test_fall_on_lp();
    int n_lp = 0;
    for (int e = 0; e < 60; e++) begin
      x0[3] = (e < 20);
      tick();
      n_vec++;
      if (obsv() !== expv()) begin
        n_err++; $display("FAIL fall_lp_model e=%0d got=%h exp=%h", e, obsv(), expv());
      end
      if (lp0[3] || rp0[3]) n_lp++;
      if (e == 29) begin
        n_vec++;
        if ({f0[3], lp0[3]} !== 2'b10) begin
          n_err++; $display("FAIL fall_wins fall_lp=%b exp=10", {f0[3], lp0[3]});
        end
      end
    end
    n_vec++;
    if (n_lp !== 0) begin
      n_err++; $display("FAIL fall_lp_pulses got=%0d exp=0", n_lp);
    end
  endtask

  task automatic test_random();
    int rem0 [NC];
    int rem1 [NC];
    for (int i = 0; i < NC; i++) begin rem0[i] = 0; rem1[i] = 0; end
    for (int e = 0; e < 1500; e++) begin
      for (int i = 0; i < NC; i++) begin
        if (rem0[i] == 0) begin x0[i] = ~x0[i]; rem0[i] = $urandom_range(1, 40); end
        else rem0[i]--;
        if (rem1[i] == 0) begin x1[i] = ~x1[i]; rem1[i] = $urandom_range(1, 40); end
        else rem1[i]--;
      end
      tick();
      n_vec++;
      if (obsv() !== expv()) begin
        n_err++; $display("FAIL random_model e=%0d got=%h exp=%h", e, obsv(), expv());
      end
    end
    x0 = '0; x1 = '1;
    for (int e = 0; e < 15; e++) begin
      tick();
      n_vec++;
      if (obsv() !== expv()) begin
        n_err++; $display("FAIL random_drain e=%0d got=%h exp=%h", e, obsv(), expv());
      end
    end
  endtask

  task automatic test_async_reset();
    int pulses = 0;
    x0 = '1; x1 = '0;
    for (int e = 0; e < 22; e++) begin
      tick();
      n_vec++;
      if (obsv() !== expv()) begin
        n_err++; $display("FAIL prereset_model e=%0d got=%h exp=%h", e, obsv(), expv());
      end
    end
    #3 rst_n = 1'b0;
    #1;
    n_vec++;
    if (obsv() !== 40'h0) begin
      n_err++; $display("FAIL async_reset got=%h exp=%h", obsv(), 40'h0);
    end
    x0 = '0; x1 = '1;
    repeat (3) tick();
    rst_n = 1'b1;
    for (int e = 0; e < 40; e++) begin
      tick();
      n_vec++;
      if (obsv() !== expv()) begin
        n_err++; $display("FAIL postreset_model e=%0d got=%h exp=%h", e, obsv(), expv());
      end
      if (obsv() !== 40'h0) pulses++;
    end
    n_vec++;
    if (pulses !== 0) begin
      n_err++; $display("FAIL postreset_quiet cycles=%0d exp=0", pulses);
    end
  endtask

  task automatic test_active_low();
    int n_lp = 0, n_rp = 0;
    n_vec++;
    if (y1 !== 4'h0) begin n_err++; $display("FAIL al_idle y=%h exp=0", y1); end
    for (int e = 0; e < 80; e++) begin
      x1[0] = (e < 40) ? 1'b0 : 1'b1;
      tick();
      n_vec++;
      if (obsv() !== expv()) begin
        n_err++; $display("FAIL al_model e=%0d got=%h exp=%h", e, obsv(), expv());
      end
      if (lp1[0]) n_lp++;
      if (rp1[0]) n_rp++;
      if (e == 9) begin
        n_vec++;
        if ({y1[0], r1[0]} !== 2'b11) begin
          n_err++; $display("FAIL al_rise y_rise=%b exp=11", {y1[0], r1[0]});
        end
      end
    end
    n_vec++;
    if (n_lp !== 1 || n_rp !== 0) begin
      n_err++; $display("FAIL al_hold lp=%0d rp=%0d exp lp=1 rp=0", n_lp, n_rp);
    end
  endtask

  initial begin
    test_reset();
    test_edge_latency();
    test_bounce();
    test_hold_repeat();
    test_fall_on_lp();
    test_active_low();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
